// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - register offsets, STATUS bit indices and FSM encodings for uart_mmio
package uart_mmio_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_RXDATA = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int BIT_TX_FULL     = 0;
  localparam int BIT_TX_EMPTY    = 1;
  localparam int BIT_TX_BUSY     = 2;
  localparam int BIT_RX_VALID    = 3;
  localparam int BIT_RX_OVERRUN  = 4;
  localparam int BIT_TX_OVERFLOW = 5;
  localparam int BIT_RX_FERR     = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_mmio_sync_fifo.sv
// rtl/uart_mmio_sync_fifo.sv - single-clock FIFO with extra-MSB pointers (module sync_fifo)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a push to a full FIFO is still taken.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Read/write pointers wrap modulo 2*DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// rtl/uart_mmio.sv - memory-mapped UART with TX FIFO; receiver compiled in with UART_RX_EN
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] data_address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx,
  input  logic        rx
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  logic        sel;
  logic [1:0]  off;
  logic        wr_txdata;
  logic        wr_status;
  logic        rd_rxdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        tx_pop;
  logic        tx_overflow;
  uart_state_t tx_state;
  logic [CW-1:0] tx_baud;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        rx_valid;
  logic        rx_overrun;
  logic        rx_ferr;
  logic [7:0]  rx_byte;
  logic [31:0] status;
  logic        unused_bits;

  assign sel       = (data_address[31:4] == BASE_ADDR[31:4]);
  assign off       = data_address[3:2];
  assign wr_txdata = sel && memwrite && (off == OFF_TXDATA);
  assign wr_status = sel && memwrite && (off == OFF_STATUS);
  assign rd_rxdata = sel && memread  && (off == OFF_RXDATA);
  assign unused_bits = ^{data_address[1:0], writedata};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (tx_pop),
    .wdata (writedata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pop when idle, or at the last stop-bit cycle so frames run back to back.
  always_comb begin
    tx_pop = !fifo_empty && ((tx_state == IDLE) || ((tx_state == STOP) && (tx_baud == BAUD_LAST)));
  end

  // TX FSM with registered line output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          if (tx_pop) begin
            tx_shift <= fifo_rdata;
            tx_baud  <= '0;
            tx       <= 1'b0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_baud == BAUD_LAST) begin
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx       <= tx_shift[0];
            tx_state <= DATA;
          end else begin
            tx_baud <= tx_baud + CW'(1);
          end
        end
        DATA: begin
          if (tx_baud == BAUD_LAST) begin
            tx_baud <= '0;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx       <= tx_shift[1];
            end
          end else begin
            tx_baud <= tx_baud + CW'(1);
          end
        end
        STOP: begin
          if (tx_baud == BAUD_LAST) begin
            tx_baud <= '0;
            if (tx_pop) begin
              tx_shift <= fifo_rdata;
              tx       <= 1'b0;
              tx_state <= START;
            end else begin
              tx_state <= IDLE;
            end
          end else begin
            tx_baud <= tx_baud + CW'(1);
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // Sticky overflow: set on a dropped push, cleared by writing 1 to its STATUS bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_overflow <= 1'b0;
    end else if (wr_txdata && fifo_full && !tx_pop) begin
      tx_overflow <= 1'b1;
    end else if (wr_status && writedata[BIT_TX_OVERFLOW]) begin
      tx_overflow <= 1'b0;
    end
  end

`ifdef UART_RX_EN
  localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_s1;
  logic          rx_s2;
  logic          rx_d;
  uart_state_t   rx_state;
  logic [CW-1:0] rx_baud;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_stop_edge;
  logic          rx_good;
  logic          rx_bad;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign rx_stop_edge = (rx_state == STOP) && (rx_baud == BAUD_LAST);
  assign rx_good      = rx_stop_edge && rx_s2;
  assign rx_bad       = rx_stop_edge && !rx_s2;

  // RX FSM: half-bit start qualification, then mid-bit sampling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        IDLE: begin
          if (rx_d && !rx_s2) begin
            rx_baud  <= '0;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_baud == BAUD_HALF) begin
            rx_baud <= '0;
            rx_bit  <= '0;
            rx_state <= rx_s2 ? IDLE : DATA;
          end else begin
            rx_baud <= rx_baud + CW'(1);
          end
        end
        DATA: begin
          if (rx_baud == BAUD_LAST) begin
            rx_baud  <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_baud <= rx_baud + CW'(1);
          end
        end
        STOP: begin
          if (rx_baud == BAUD_LAST) begin
            rx_baud  <= '0;
            rx_state <= IDLE;
          end else begin
            rx_baud <= rx_baud + CW'(1);
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // Receive flags: RXDATA read clears, a completing byte on the same edge wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_byte    <= '0;
    end else begin
      if (rd_rxdata) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
        rx_ferr    <= 1'b0;
      end
      if (rx_good) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
        if (rx_valid && !rd_rxdata) rx_overrun <= 1'b1;
      end
      if (rx_bad) rx_ferr <= 1'b1;
    end
  end
`else
  logic unused_rx;

  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign rx_ferr    = 1'b0;
  assign rx_byte    = '0;
  assign unused_rx  = ^{rx, rd_rxdata};
`endif

  // STATUS assembly and selected-register read mux.
  always_comb begin
    status                  = '0;
    status[BIT_TX_FULL]     = fifo_full;
    status[BIT_TX_EMPTY]    = fifo_empty;
    status[BIT_TX_BUSY]     = (tx_state != IDLE);
    status[BIT_RX_VALID]    = rx_valid;
    status[BIT_RX_OVERRUN]  = rx_overrun;
    status[BIT_TX_OVERFLOW] = tx_overflow;
    status[BIT_RX_FERR]     = rx_ferr;
    readdata                = '0;
    if (sel && memread) begin
      case (off)
        OFF_STATUS: readdata = status;
        OFF_RXDATA: readdata = {24'b0, rx_byte};
        default:    readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// tb/tb_uart_mmio.sv - scoreboard bench for uart_mmio (RX checks adapt to UART_RX_EN)
module tb_uart_mmio;

  localparam int CPB = 4;
`ifdef UART_RX_EN
  localparam bit RX_ON = 1'b1;
`else
  localparam bit RX_ON = 1'b0;
`endif

  localparam logic [31:0] A_TX  = 32'hFFFF_0000;
  localparam logic [31:0] A_ST  = 32'hFFFF_0004;
  localparam logic [31:0] A_RX  = 32'hFFFF_0008;
  localparam logic [31:0] A_RSV = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] data_address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        tx;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rst_cnt = 0;
  logic [7:0] tx_exp[$];
  int starts[$];

  uart_mmio #(.BASE_ADDR(32'hFFFF_0000), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
    .data_address(data_address), .writedata(writedata), .readdata(readdata),
    .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge reset) rst_cnt <= rst_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    data_address = a; writedata = d; memwrite = 1'b1;
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    data_address = a; memread = 1'b1;
    #1 d = readdata;
    @(negedge clk);
    memread = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] e);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stp);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stp;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  // Line monitor: decodes each frame mid-bit and checks it against the scoreboard.
  initial begin : tx_mon
    logic [7:0] b;
    logic stp;
    int r0;
    int st;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        r0 = rst_cnt;
        st = cyc;
        b = '0;
        for (int i = 0; i < 8; i++) begin
          repeat ((i == 0) ? CPB + 1 : CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stp = tx;
        if (rst_cnt == r0) begin
          starts.push_back(st);
          chk("tx_frame_expected", 32'(tx_exp.size() != 0), 32'd1);
          if (tx_exp.size() != 0) begin
            chk("tx_byte", 32'(b), 32'(tx_exp.pop_front()));
            chk("tx_stop", 32'(stp), 32'd1);
          end
        end
      end
    end
  end

  initial begin : main
    int nst;
    idle(3);
    reset = 1'b0;
    chk("rst_tx", 32'(tx), 32'd1);
    rd_chk("rst_status", A_ST, 32'h2);
    rd_chk("rst_rxdata", A_RX, 32'h0);
    data_address = A_ST;
    #1 chk("rd_gate_memread0", readdata, 32'h0);
    idle(1);
    rd_chk("rd_unselected", 32'hFFFF_0014, 32'h0);
    rd_chk("rd_low_bits_ignored", 32'hFFFF_0007, 32'h2);
    wr(A_RSV, 32'hFFFF_FFFF);
    rd_chk("rd_reserved", A_RSV, 32'h0);
    rd_chk("rd_txdata_zero", A_TX, 32'h0);

    // single frame and write-to-line latency
    tx_exp.push_back(8'h55);
    wr(A_TX, 32'h55);
    chk("tx_lat_edge_n", 32'(tx), 32'd1);
    idle(1);
    chk("tx_lat_edge_n1", 32'(tx), 32'd0);
    rd_chk("busy_status", A_ST, 32'h6);
    idle(45);
    chk("single_drained", 32'(tx_exp.size()), 32'd0);
    rd_chk("single_idle_status", A_ST, 32'h2);

    // overflow and back-to-back frames
    starts.delete();
    for (int v = 8'h11; v <= 8'h15; v++) tx_exp.push_back(8'(v));
    for (int v = 8'h11; v <= 8'h16; v++) wr(A_TX, 32'(v));
    rd_chk("ovf_status", A_ST, 32'h25);
    wr(A_ST, 32'h0);
    rd_chk("ovf_write0_keeps", A_ST, 32'h25);
    wr(A_ST, 32'h20);
    rd_chk("ovf_cleared", A_ST, 32'h05);
    idle(210);
    chk("b2b_frame_count", 32'(starts.size()), 32'd5);
    if (starts.size() == 5)
      for (int i = 1; i < 5; i++) chk("b2b_gap", 32'(starts[i] - starts[i-1]), 32'd40);
    chk("ovf_drained", 32'(tx_exp.size()), 32'd0);
    rd_chk("ovf_idle_status", A_ST, 32'h2);

    // receive path
    send_rx(8'hA3, 1'b1);
    idle(3);
    rd_chk("rx_valid_status", A_ST, RX_ON ? 32'h0A : 32'h02);
    rd_chk("rx_data_a3", A_RX, RX_ON ? 32'hA3 : 32'h0);
    rd_chk("rx_valid_cleared", A_ST, 32'h2);
    send_rx(8'h3C, 1'b1);
    send_rx(8'hC5, 1'b1);
    idle(3);
    rd_chk("rx_overrun_status", A_ST, RX_ON ? 32'h1A : 32'h02);
    send_rx(8'h99, 1'b0);
    idle(3);
    rd_chk("rx_ferr_status", A_ST, RX_ON ? 32'h5A : 32'h02);
    rd_chk("rx_data_second", A_RX, RX_ON ? 32'hC5 : 32'h0);
    rd_chk("rx_flags_cleared", A_ST, 32'h2);
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(12);
    rd_chk("rx_glitch_no_flags", A_ST, 32'h2);

    // reset mid-frame
    nst = starts.size();
    tx_exp.push_back(8'h80);
    wr(A_TX, 32'h80);
    wr(A_TX, 32'h81);
    idle(10);
    chk("pre_rst_tx_low", 32'(tx), 32'd0);
    #2 reset = 1'b1;
    tx_exp.delete();
    #1 chk("rst_async_tx", 32'(tx), 32'd1);
    idle(2);
    reset = 1'b0;
    rd_chk("post_rst_status", A_ST, 32'h2);
    idle(50);
    chk("post_rst_no_frame", 32'(starts.size()), 32'(nst));
    chk("post_rst_tx_idle", 32'(tx), 32'd1);
    chk("tx_queue_empty", 32'(tx_exp.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
